key_debounce: RTL and testbench

- Input conditioning stage that sits directly upstream of the consecutive-ones Mealy detector.
- Takes a raw, asynchronous, bouncing key/line input and synchronises it to clk.
- Filters bounce with a stability counter and drives a clean level key_out; key_out is the detector's A input.
- Also emits one-cycle rise/fall pulses for event-driven consumers.

---
 rtl/key_debounce_pkg.sv | 25 ++
 rtl/key_debounce_sync_2ff.sv | 31 +++
 rtl/key_debounce.sv | 122 ++++++++++++
 tb/tb_key_debounce.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// ============================================================================
// key_debounce_pkg : shared state encodings and defaults for key_debounce
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package key_debounce_pkg;

  localparam int unsigned DEF_CNT_W   = 20;
  localparam int unsigned DEF_CNT_MAX = 999_999;

  typedef enum logic [3:0] {
    ST_LOW       = 4'b0001,
    ST_RISE_WAIT = 4'b0010,
    ST_HIGH      = 4'b0100,
    ST_FALL_WAIT = 4'b1000
  } state_e;

  function automatic logic is_wait(input state_e s);
    return (s == ST_RISE_WAIT) || (s == ST_FALL_WAIT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_debounce_sync_2ff.sv
// ============================================================================
// sync_2ff : 1-bit two-flop synchroniser, async active-low reset to 0
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

`default_nettype wire

// File: rtl/key_debounce.sv
// ============================================================================
// key_debounce : synchronise and debounce a raw key, emit level + edge pulses
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned          CNT_W   = DEF_CNT_W,
  parameter logic [CNT_W-1:0]     CNT_MAX = CNT_W'(DEF_CNT_MAX)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_out,
  output logic key_rise,
  output logic key_fall,
  output logic busy
);

  logic             s2;
  state_e           state_q,    state_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic             key_out_q,  key_out_d;
  logic             key_rise_q, key_rise_d;
  logic             key_fall_q, key_fall_d;
  logic             busy_q,     busy_d;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (key_in),
    .q     (s2)
  );

  // Abort on an opposite sample is tested before the terminal count.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    key_out_d  = key_out_q;
    key_rise_d = 1'b0;
    key_fall_d = 1'b0;
    case (state_q)
      ST_LOW: begin
        if (s2) begin
          state_d = ST_RISE_WAIT;
          cnt_d   = '0;
        end
      end
      ST_RISE_WAIT: begin
        if (!s2) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d    = ST_HIGH;
          cnt_d      = '0;
          key_out_d  = 1'b1;
          key_rise_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HIGH: begin
        if (!s2) begin
          state_d = ST_FALL_WAIT;
          cnt_d   = '0;
        end
      end
      ST_FALL_WAIT: begin
        if (s2) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d    = ST_LOW;
          cnt_d      = '0;
          key_out_d  = 1'b0;
          key_fall_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = ST_LOW;
        cnt_d     = '0;
        key_out_d = 1'b0;
      end
    endcase
    busy_d = is_wait(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LOW;
      cnt_q      <= '0;
      key_out_q  <= 1'b0;
      key_rise_q <= 1'b0;
      key_fall_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      key_out_q  <= key_out_d;
      key_rise_q <= key_rise_d;
      key_fall_q <= key_fall_d;
      busy_q     <= busy_d;
    end
  end

  assign key_out  = key_out_q;
  assign key_rise = key_rise_q;
  assign key_fall = key_fall_q;
  assign busy     = busy_q;

  a_one_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    !(key_rise_q && key_fall_q));
  a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
    cnt_q <= CNT_MAX);

endmodule

`default_nettype wire

// File: tb/tb_key_debounce.sv
// ============================================================================
// tb_key_debounce : scoreboard bench for key_debounce (CNT_MAX=4, CNT_W=4)
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_key_debounce;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CNT_MAX = 4;
  localparam int unsigned LAT     = CNT_MAX + 4;

  logic clk = 1'b0;
  logic rst_n;
  logic key_in;
  logic key_out, key_rise, key_fall, busy;

  key_debounce #(
    .CNT_W   (CNT_W),
    .CNT_MAX (CNT_W'(CNT_MAX))
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_in   (key_in),
    .key_out  (key_out),
    .key_rise (key_rise),
    .key_fall (key_fall),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference: s2 is key_in delayed two edges; the level flips on the
  // (CNT_MAX+2)-th consecutive s2 sample that differs from it.
  logic m_s1 = 1'b0, m_s2 = 1'b0, m_out = 1'b0;
  int   m_run = 0;

  logic [3:0] sb_q[$];

  int   edge_n, first_edge, rise_cnt, fall_cnt, toggles;
  logic track_lvl, prev_out;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 1'b0; m_s2 = 1'b0; m_out = 1'b0; m_run = 0;
  endtask

  task automatic model_step(input logic k, output logic [3:0] e);
    logic samp, r, f, b;
    samp = m_s2;
    m_s2 = m_s1;
    m_s1 = k;
    r = 1'b0; f = 1'b0; b = 1'b0;
    if (samp != m_out) begin
      m_run++;
      if (m_run == int'(CNT_MAX) + 2) begin
        m_out = samp;
        r = samp;
        f = ~samp;
        m_run = 0;
      end else begin
        b = 1'b1;
      end
    end else begin
      m_run = 0;
    end
    e = {m_out, r, f, b};
  endtask

  task automatic step(input logic k);
    logic [3:0] e;
    key_in = k;
    @(posedge clk);
    edge_n++;
    model_step(k, e);
    sb_q.push_back(e);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      chk("sb_outs", {key_out, key_rise, key_fall, busy}, sb_q.pop_front());
    end
    if (first_edge == 0 && key_out == track_lvl) first_edge = edge_n;
    rise_cnt += int'(key_rise);
    fall_cnt += int'(key_fall);
    if (key_out != prev_out) toggles++;
    prev_out = key_out;
  endtask

  task automatic track(input logic lvl);
    edge_n = 0; first_edge = 0; track_lvl = lvl;
    rise_cnt = 0; fall_cnt = 0; toggles = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    key_in = 1'b0;
    prev_out = 1'b0;
    track(1'b1);
    repeat (3) @(negedge clk);
    chk("reset_outs", {key_out, key_rise, key_fall, busy}, 4'b0000);
    rst_n = 1'b1;

    // Idle low
    track(1'b1);
    repeat (20) step(1'b0);
    chk("idle_pulses", rise_cnt + fall_cnt, 0);
    chk("idle_level", first_edge, 0);

    // Clean rise
    track(1'b1);
    repeat (12) step(1'b1);
    chk("rise_latency", first_edge, LAT);
    chk("rise_pulses", rise_cnt, 1);

    // Clean fall
    track(1'b0);
    repeat (12) step(1'b0);
    chk("fall_latency", first_edge, LAT);
    chk("fall_pulses", fall_cnt, 1);
    chk("fall_no_rise", rise_cnt, 0);

    // Bounce, then a final rise held
    track(1'b1);
    repeat (3) step(1'b1);
    step(1'b0);
    chk("bounce_no_rise", rise_cnt, 0);
    track(1'b1);
    repeat (12) step(1'b1);
    chk("bounce_latency", first_edge, LAT);
    chk("bounce_pulses", rise_cnt, 1);

    // Back low, then async reset in the middle of a rise qualification
    repeat (12) step(1'b0);
    track(1'b1);
    repeat (5) step(1'b1);
    chk("pre_rst_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1 chk("async_rst_outs", {key_out, key_rise, key_fall, busy}, 4'b0000);
    model_reset();
    prev_out = 1'b0;
    #1 rst_n = 1'b1;
    track(1'b1);
    repeat (12) step(1'b1);
    chk("post_rst_latency", first_edge, LAT);

    // Long hold: downstream level must be monotonic
    repeat (12) step(1'b0);
    track(1'b1);
    repeat (40) step(1'b1);
    chk("hold_toggles", toggles, 1);
    chk("hold_level", key_out, 1);
    chk("sb_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1);
  end

endmodule

`default_nettype wire
